// File: rtl/wlink_tb_ctrl.sv
// wlink_tb_ctrl: sequences harness reset, monitors NUM_CH channels for completion/errors, reports a verdict.
// Optional watchdog timeout is enabled by defining WLINK_TB_CTRL_WATCHDOG_EN.
module wlink_tb_ctrl #(
   parameter int NUM_CH         = 4,
   parameter int RESET_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int CNT_W          = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic [NUM_CH-1:0] ch_finished,
   input  logic [NUM_CH-1:0] ch_error,
   input  logic              restart,
   output logic              harness_reset,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [NUM_CH-1:0] err_ch,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int               RST_W    = $clog2(RESET_CYCLES + 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Elaboration-time parameter sanity checks.
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("NUM_CH must be at least 1");
   end
   if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
   if (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [RST_W-1:0]  rst_cnt;
   logic [NUM_CH-1:0] fin_latch;
   logic [NUM_CH-1:0] err_next;
   logic [NUM_CH-1:0] fin_next;
   logic [CNT_W-1:0]  cnt_next;
   logic              all_done;
   logic              wd_hit;

   // Next-value terms shared by RUN and DRAIN; a disabled channel counts as finished.
   always_comb begin
      err_next = err_ch | (ch_error & ch_enable);
      fin_next = fin_latch | (ch_finished & ch_enable);
      all_done = &(fin_next | ~ch_enable);
      if (cycle_count == CNT_MAX) begin
         cnt_next = cycle_count;
      end else begin
         cnt_next = cycle_count + CNT_W'(1'b1);
      end
   end

`ifdef WLINK_TB_CTRL_WATCHDOG_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   assign wd_hit = (cycle_count == TO_LAST);
`else
   assign wd_hit = 1'b0;
`endif

   // Controller state machine with all outputs registered; restart in DONE behaves like reset.
   always_ff @(posedge clock) begin
      if (reset || (state == ST_DONE && restart)) begin
         state         <= ST_RST;
         rst_cnt       <= '0;
         fin_latch     <= '0;
         harness_reset <= 1'b1;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         timeout       <= 1'b0;
         err_ch        <= '0;
         cycle_count   <= '0;
      end else begin
         case (state)
            ST_RST: begin
               if (rst_cnt == RST_LAST) begin
                  state         <= ST_RUN;
                  harness_reset <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt + RST_W'(1'b1);
               end
            end
            ST_RUN: begin
               err_ch      <= err_next;
               fin_latch   <= fin_next;
               cycle_count <= cnt_next;
               if (all_done) begin
                  state <= ST_DRAIN;
               end else if (wd_hit) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  fail    <= 1'b1;
                  pass    <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Late errors arriving in DRAIN still count toward the verdict.
               err_ch <= err_next;
               state  <= ST_DONE;
               done   <= 1'b1;
               fail   <= |err_next;
               pass   <= ~|err_next;
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state         <= ST_RST;
               rst_cnt       <= '0;
               harness_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wlink_tb_ctrl.sv
// Self-checking bench for wlink_tb_ctrl: per-cycle comparison against a behavioural model plus
// hand-computed expectations for each directed scenario.
module tb_wlink_tb_ctrl;

   localparam int NUM_CH = 4;
   localparam int RC     = 16;
   localparam int TO     = 100;
   localparam int CW     = 8;
   localparam int CMAX   = 255;
`ifdef WLINK_TB_CTRL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_CH-1:0] ch_enable = '0;
   logic [NUM_CH-1:0] ch_finished = '0;
   logic [NUM_CH-1:0] ch_error = '0;
   logic              restart = 1'b0;
   logic              harness_reset, done, pass, fail, timeout;
   logic [NUM_CH-1:0] err_ch;
   logic [CW-1:0]     cycle_count;

   wlink_tb_ctrl #(.NUM_CH(NUM_CH), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .ch_enable(ch_enable), .ch_finished(ch_finished),
      .ch_error(ch_error), .restart(restart), .harness_reset(harness_reset), .done(done),
      .pass(pass), .fail(fail), .timeout(timeout), .err_ch(err_ch), .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a countdown of reset cycles, then running/draining/finished flags.
   bit        started = 1'b0;
   int        m_rst_left;
   bit        m_running, m_draining, m_finished;
   bit        m_hr, m_pass, m_fail, m_to;
   int        m_cnt;
   logic [3:0] m_err, m_fin;

   task automatic model_clear();
      m_rst_left = RC; m_running = 0; m_draining = 0; m_finished = 0;
      m_hr = 1; m_pass = 0; m_fail = 0; m_to = 0; m_cnt = 0; m_err = '0; m_fin = '0;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         started = 1'b1;
         if (reset || (m_finished && restart)) begin
            model_clear();
         end else if (m_finished) begin
            // verdict holds
         end else if (m_draining) begin
            m_err = m_err | (ch_error & ch_enable);
            m_draining = 0; m_finished = 1;
            m_fail = (m_err != 4'b0000); m_pass = !m_fail;
         end else if (m_running) begin
            bit every, limit;
            m_err = m_err | (ch_error & ch_enable);
            m_fin = m_fin | (ch_finished & ch_enable);
            every = ((m_fin | ~ch_enable) == 4'b1111);
            limit = WD && (m_cnt == TO - 1);
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (every) begin
               m_running = 0; m_draining = 1;
            end else if (limit) begin
               m_running = 0; m_finished = 1; m_to = 1; m_fail = 1; m_pass = 0;
            end
         end else begin
            m_rst_left--;
            if (m_rst_left == 0) begin m_running = 1; m_hr = 0; end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clock);
         if (started) begin
            check("harness_reset", harness_reset, m_hr);
            check("done", done, m_finished);
            check("pass", pass, m_pass);
            check("fail", fail, m_fail);
            check("timeout", timeout, m_to);
            check("err_ch", err_ch, m_err);
            check("cycle_count", cycle_count, m_cnt);
         end
      end
   end

   task automatic step();
      @(negedge clock);
   endtask

   // Counts cycles with harness_reset high, starting at the current cycle.
   task automatic count_reset(output int n);
      n = 0;
      while (harness_reset === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic do_restart(output int n);
      restart = 1'b1;
      step();
      restart = 1'b0;
      ch_finished = '0;
      ch_error = '0;
      count_reset(n);
   endtask

   int n, dcyc;

   initial begin
      // Reset release
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      count_reset(n);
      check("reset_len", n, 16);

      // All four finish at 10/20/30/40; a restart in RUN is ignored
      ch_enable = 4'hF;
      dcyc = -1;
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < NUM_CH; i++) ch_finished[i] = (c >= 10 * (i + 1));
         restart = (c == 3);
         step();
         if (done === 1'b1) begin dcyc = c + 1; break; end
      end
      restart = 1'b0;
      check("s2_done_cycle", dcyc, 42);
      check("s2_count", cycle_count, 41);
      check("s2_pass", pass, 1);

      // Errors in RUN and DRAIN, channel 3 disabled mid-RUN
      do_restart(n);
      check("restart_reset_len", n, 16);
      check("restart_err_clear", err_ch, 0);
      dcyc = -1;
      for (int c = 0; c < 30; c++) begin
         ch_error = (c == 5) ? 4'b0100 : (c == 6) ? 4'b1000 : (c == 9) ? 4'b0010 : 4'b0000;
         ch_enable = (c >= 6) ? 4'b0111 : 4'b1111;
         ch_finished = (c >= 8) ? 4'b0111 : 4'b0000;
         step();
         if (done === 1'b1) begin dcyc = c + 1; break; end
      end
      ch_error = '0;
      check("s3_done_cycle", dcyc, 10);
      check("s3_err_ch", err_ch, 4'b0110);
      check("s3_fail", fail, 1);
      check("s3_pass", pass, 0);

      // Finish and watchdog coincide at count 99
      do_restart(n);
      ch_enable = 4'hF;
      dcyc = -1;
      for (int c = 0; c < 200; c++) begin
         ch_finished = (c >= 99) ? 4'hF : 4'h0;
         step();
         if (done === 1'b1) begin dcyc = c + 1; break; end
      end
      check("s5_done_cycle", dcyc, 101);
      check("s5_count", cycle_count, 100);
      check("s5_pass", pass, 1);
      check("s5_timeout", timeout, 0);

      // One channel never finishes
      do_restart(n);
      ch_enable = 4'b0001;
      ch_finished = '0;
      dcyc = -1;
      for (int c = 0; c < 300; c++) begin
         step();
         if (done === 1'b1) begin dcyc = c + 1; break; end
      end
      if (WD) begin
         check("s4_done_cycle", dcyc, 100);
         check("s4_count", cycle_count, 100);
         check("s4_timeout", timeout, 1);
         check("s4_fail", fail, 1);
      end else begin
         check("s4_no_done", done, 0);
         check("s4_saturated", cycle_count, 8'hFF);
         check("s4_still_run", harness_reset, 0);
      end

      // Reset out of DONE/RUN, then empty enable mask
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_reset(n);
      check("s6_reset_len", n, 16);
      ch_enable = 4'h0;
      dcyc = -1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (done === 1'b1) begin dcyc = c + 1; break; end
      end
      check("s6_empty_done_cycle", dcyc, 2);
      check("s6_empty_count", cycle_count, 1);
      check("s6_empty_pass", pass, 1);

      // Reset mid-RUN with a recorded error
      do_restart(n);
      ch_enable = 4'hF;
      for (int c = 0; c < 5; c++) begin
         ch_error = (c == 2) ? 4'hF : 4'h0;
         step();
      end
      ch_error = '0;
      check("s7_err_before", err_ch, 4'hF);
      reset = 1'b1;
      step();
      check("s7_hr", harness_reset, 1);
      check("s7_done", done, 0);
      check("s7_count", cycle_count, 0);
      check("s7_err", err_ch, 0);
      reset = 1'b0;
      count_reset(n);
      check("s7_reset_len", n, 16);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wlink_tb_ctrl.md
# wlink_tb_ctrl

Synthesizable, parametrised simulation/emulation test controller for Wlink harnesses. It sequences harness reset, monitors `NUM_CH` independent harness channels for completion and errors, and runs a cycle-accurate watchdog. It reports a registered pass/fail/timeout verdict. It sits between the bench clock/reset source and one or more `WlinkSimpleTestHarness`-style instances, and can run on FPGA emulation where behavioural delays and `$finish` are unavailable.

## Interface
Parameters:
- `NUM_CH`, 4: number of monitored harness channels (≥1).
- `RESET_CYCLES`, 16: cycles `harness_reset` is held after controller reset releases (≥1).
- `TIMEOUT_CYCLES`, 5000000: RUN cycles allowed before watchdog fires (≥2).
- `CNT_W`, 32: width of `cycle_count`; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ch_enable`  in  NUM_CH  per-channel participation mask; sampled every cycle.
- `ch_finished`  in  NUM_CH  per-channel finished level from harnesses.
- `ch_error`  in  NUM_CH  per-channel error level from harnesses.
- `restart`  in  1  single-cycle pulse; rerun the sequence from DONE.
- `harness_reset`  out  1  reset driven to harnesses.
- `done`  out  1  verdict valid.
- `pass`  out  1  done with no error and no timeout.
- `fail`  out  1  done with any error or timeout.
- `timeout`  out  1  watchdog fired.
- `err_ch`  out  NUM_CH  sticky per-channel error record.
- `cycle_count`  out  CNT_W  RUN-state cycle count, saturating.

## Operation
- States: RST, RUN, DRAIN, DONE. Reset state RST.
- RST: `harness_reset`=1. The internal counter runs 0..RESET_CYCLES-1, then RUN. `cycle_count`, finished latches, `err_ch`, and `timeout` are cleared on entry. Harness inputs are ignored.
- RUN: `harness_reset`=0. A per-channel finished latch sets on `ch_finished[i]`. Errors are sampled as `err_ch |= ch_error & ch_enable`. `cycle_count` increments.
  - If every enabled channel's latch is set (including the current cycle's input) → DRAIN.
  - Else if `cycle_count` == TIMEOUT_CYCLES-1 → DONE with `timeout`=1.
  - Finish takes priority over timeout in the same cycle.
- DRAIN: one cycle. Errors are still sampled, so late errors are caught. Then → DONE.
- DONE: `done`=1. `fail` = `|err_ch | timeout`. `pass` = `done & ~fail`. Error sampling stops and outputs hold.
  - `restart`=1 → RST, which clears the verdict.
- `ch_enable` all-zero: the all-finished condition is true in the first RUN cycle → DRAIN → DONE, pass.
- A channel deasserting `ch_finished` after latching has no effect.
- Disabled channels are never latched and never recorded in `err_ch`. Disabling a channel mid-RUN removes it from the completion condition from that cycle on.
- `restart` outside DONE is ignored.

## Timing
- Values during and the cycle after `reset`:
  - State RST, `harness_reset`=1.
  - `done`, `pass`, `fail`, `timeout` = 0.
  - `err_ch` = 0, `cycle_count` = 0.
- `harness_reset` is high for exactly RESET_CYCLES cycles after the first non-reset edge. It falls registered on the edge entering RUN.
- All outputs are registered, with no combinational input-to-output paths.
- Latency from the all-finished edge: the DRAIN edge, then `done` on the next edge. The verdict therefore appears 2 cycles after the finishing input is sampled.
- Timeout: `done`, `timeout`, and `fail` rise together on the edge after `cycle_count` reaches TIMEOUT_CYCLES-1.
- `cycle_count` holds its value in DRAIN and DONE, and saturates at all-ones.
- `reset` asserted in any state returns to the reset values on the next edge.

## Configuration
- `WLINK_TB_CTRL_WATCHDOG_EN` defined:
  - Timeout logic is present as described.
- `WLINK_TB_CTRL_WATCHDOG_EN` undefined:
  - The watchdog compare is removed and `timeout` is tied to 0.
  - RUN exits only via completion.
  - `cycle_count` still counts and saturates.

## Test plan
- Reset release, NUM_CH=4, RESET_CYCLES=16 → `harness_reset` is high for exactly 16 cycles after `reset` falls, and all other outputs stay 0.
- All 4 channels enabled. Channels finish at RUN cycles 10, 20, 30, 40 and no errors occur → `done`=`pass`=1 two cycles after cycle 40, and `cycle_count`=41.
- Channel 2 asserts `ch_error` for one cycle in RUN; channel 1 errors during DRAIN → `err_ch`=4'b0110 and `fail`=1. An error pulse on channel 3 while it is disabled is not recorded.
- TIMEOUT_CYCLES=100 with one channel never finishing → `done`=`timeout`=`fail`=1 with `cycle_count`=100. With the macro undefined, the controller stays in RUN.
- Finish and timeout coincide at cycle_count 99 → DRAIN then pass, with `timeout`=0.
- `restart` in DONE → re-enters RST, `err_ch` clears, and 16 reset cycles repeat. `ch_enable`=0 → pass 2 cycles after RUN entry. `reset` mid-RUN → all outputs return to reset values on the next edge.
